// File: rtl/controller_debouncer.sv
// controller_debouncer
// Conditions the six raw breadboard push-buttons for the controller decode
// stage. Each button is synchronised through two flops, then debounced by
// its own saturating counter. The debounced level only changes after the
// synchronised input has disagreed with it for DEBOUNCE_CYCLES consecutive
// clocks. Attack and parry additionally get a registered one-cycle strobe
// on every debounced press. All outputs come straight from flops, so there
// is no combinational path from a raw input to any output.
module controller_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic up_raw,
    input  logic down_raw,
    input  logic attack_raw,
    input  logic parry_raw,
    output logic left_db,
    output logic right_db,
    output logic up_db,
    output logic down_db,
    output logic attack_db,
    output logic parry_db,
    output logic attack_pulse,
    output logic parry_pulse
);

    // Terminal count. DEBOUNCE_CYCLES may be as large as 2^CNT_W, so
    // DEBOUNCE_CYCLES-1 always fits in the counter width.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index order: 0 left, 1 right, 2 up, 3 down, 4 attack, 5 parry.
    localparam int ATTACK_IDX = 4;
    localparam int PARRY_IDX  = 5;

    logic [5:0]       w_raw;
    logic [5:0]       w_differs;
    logic [5:0]       w_commit;
    logic [5:0]       r_s1;
    logic [5:0]       r_s2;
    logic [5:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [6];
    logic             r_attackPulse;
    logic             r_parryPulse;

    assign w_raw = {parry_raw, attack_raw, down_raw, up_raw, right_raw, left_raw};

    // Per channel: does the synchronised level disagree with the stable
    // level, and has it disagreed long enough to be accepted this edge?
    always_comb begin
        w_differs = '0;
        w_commit  = '0;
        for (int g = 0; g < 6; g++) begin
            w_differs[g] = (r_s2[g] != r_stable[g]);
            w_commit[g]  = w_differs[g] && (r_cnt[g] >= LAST_COUNT);
        end
    end

    // Two-flop synchroniser bringing the asynchronous buttons into clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce counters and stable levels; any agreement restarts the count,
    // and the count is cleared on acceptance so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int g = 0; g < 6; g++) begin
                r_cnt[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 6; g++) begin
                if (!w_differs[g]) begin
                    r_cnt[g] <= '0;
                end else if (w_commit[g]) begin
                    r_stable[g] <= r_s2[g];
                    r_cnt[g]    <= '0;
                end else begin
                    r_cnt[g] <= r_cnt[g] + 1'b1;
                end
            end
        end
    end

    // Press strobes fire on the same edge the stable level rises, so each
    // strobe lines up with the first high cycle of the debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_attackPulse <= 1'b0;
            r_parryPulse  <= 1'b0;
        end else begin
            r_attackPulse <= w_commit[ATTACK_IDX] && r_s2[ATTACK_IDX];
            r_parryPulse  <= w_commit[PARRY_IDX] && r_s2[PARRY_IDX];
        end
    end

    assign left_db      = r_stable[0];
    assign right_db     = r_stable[1];
    assign up_db        = r_stable[2];
    assign down_db      = r_stable[3];
    assign attack_db    = r_stable[ATTACK_IDX];
    assign parry_db     = r_stable[PARRY_IDX];
    assign attack_pulse = r_attackPulse;
    assign parry_pulse  = r_parryPulse;

endmodule

// File: tb/tb_controller_debouncer.sv
// tb_controller_debouncer
// Drives the debouncer with directed button scenarios followed by random
// per-button bounce patterns, and compares every cycle against a behavioural
// model that tracks, per button, how long the synchronised level has been
// disagreeing with the accepted level.
module tb_controller_debouncer;

    localparam int DEBOUNCE = 4;
    localparam int SYNC_DEPTH = 2;

    // Bit order of raw/db vectors: 0 left, 1 right, 2 up, 3 down, 4 attack, 5 parry
    localparam logic [5:0] LEFT   = 6'b000001;
    localparam logic [5:0] RIGHT  = 6'b000010;
    localparam logic [5:0] UP     = 6'b000100;
    localparam logic [5:0] DOWN   = 6'b001000;
    localparam logic [5:0] ATTACK = 6'b010000;
    localparam logic [5:0] PARRY  = 6'b100000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] rawVec = 6'h3f;

    logic left_db, right_db, up_db, down_db, attack_db, parry_db;
    logic attack_pulse, parry_pulse;
    logic [7:0] obsVec;
    logic [7:0] expVec;

    int nChecks = 0;
    int nErrors = 0;

    controller_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .left_raw(rawVec[0]),
        .right_raw(rawVec[1]),
        .up_raw(rawVec[2]),
        .down_raw(rawVec[3]),
        .attack_raw(rawVec[4]),
        .parry_raw(rawVec[5]),
        .left_db(left_db),
        .right_db(right_db),
        .up_db(up_db),
        .down_db(down_db),
        .attack_db(attack_db),
        .parry_db(parry_db),
        .attack_pulse(attack_pulse),
        .parry_pulse(parry_pulse)
    );

    assign obsVec = {parry_pulse, attack_pulse, parry_db, attack_db,
                     down_db, up_db, right_db, left_db};

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Behavioural reference: the button history seen by the clock is delayed
    // by the synchroniser depth; the accepted level flips once the delayed
    // history has disagreed with it for DEBOUNCE edges in a row.
    logic [5:0] seenHist [SYNC_DEPTH];
    logic [5:0] mStable = '0;
    int         mRun [6];
    logic       mAtkPulse = 1'b0;
    logic       mParPulse = 1'b0;
    logic [5:0] mPrevStable;
    logic [5:0] mDelayed;

    initial begin
        for (int i = 0; i < SYNC_DEPTH; i++) seenHist[i] = '0;
        for (int i = 0; i < 6; i++) mRun[i] = 0;
    end

    // Advance the reference model on every rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DEPTH; i++) seenHist[i] = '0;
            for (int i = 0; i < 6; i++) mRun[i] = 0;
            mStable   = '0;
            mAtkPulse = 1'b0;
            mParPulse = 1'b0;
        end else begin
            mPrevStable = mStable;
            mDelayed    = seenHist[SYNC_DEPTH-1];
            for (int ch = 0; ch < 6; ch++) begin
                if (mDelayed[ch] != mStable[ch]) begin
                    mRun[ch] = mRun[ch] + 1;
                    if (mRun[ch] == DEBOUNCE) begin
                        mStable[ch] = mDelayed[ch];
                        mRun[ch]    = 0;
                    end
                end else begin
                    mRun[ch] = 0;
                end
            end
            mAtkPulse = !mPrevStable[4] && mStable[4];
            mParPulse = !mPrevStable[5] && mStable[5];
            for (int i = SYNC_DEPTH - 1; i > 0; i--) seenHist[i] = seenHist[i-1];
            seenHist[0] = rawVec;
        end
    end

    assign expVec = {mParPulse, mAtkPulse, mStable};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Check the previous edge's result against the model, then drive the
    // next cycle's inputs away from the rising edge.
    task automatic applyStimulus(input logic [5:0] raw, input logic rst);
        @(negedge clk);
        checkOutput("modelCompare", {24'b0, obsVec}, {24'b0, expVec});
        rawVec = raw;
        reset  = rst;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus('0, 1'b0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, observed running, expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int holdLeft [6];
        logic [5:0] rnd;
        int pulseCount;

        // Reset held three cycles with every button pressed.
        for (int k = 0; k < 3; k++) applyStimulus(6'h3f, 1'b1);
        @(negedge clk);
        checkOutput("resetOutputs", {24'b0, obsVec}, 32'h0);

        // Release reset with buttons still held: all levels rise together.
        applyStimulus(6'h3f, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            applyStimulus(6'h3f, 1'b0);
            checkOutput("postResetDb", {26'b0, obsVec[5:0]}, (k >= 7) ? 32'h3f : 32'h0);
            checkOutput("postResetPulse", {30'b0, obsVec[7:6]}, (k == 7) ? 32'h3 : 32'h0);
        end
        idle(10);

        // Clean attack press and release.
        applyStimulus(ATTACK, 1'b0);
        for (int k = 2; k <= 10; k++) begin
            applyStimulus(ATTACK, 1'b0);
            checkOutput("pressAttackDb", {31'b0, attack_db}, (k >= 7) ? 32'h1 : 32'h0);
            checkOutput("pressAttackPulse", {31'b0, attack_pulse}, (k == 7) ? 32'h1 : 32'h0);
        end
        applyStimulus('0, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            applyStimulus('0, 1'b0);
            checkOutput("releaseAttackDb", {31'b0, attack_db}, (k >= 7) ? 32'h0 : 32'h1);
            checkOutput("releaseAttackPulse", {31'b0, attack_pulse}, 32'h0);
        end
        idle(4);

        // Bouncy left press that must be rejected.
        applyStimulus(LEFT, 1'b0);
        applyStimulus('0, 1'b0);
        applyStimulus(LEFT, 1'b0);
        applyStimulus('0, 1'b0);
        applyStimulus(LEFT, 1'b0);
        applyStimulus(LEFT, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus('0, 1'b0);
            checkOutput("bounceLeftDb", {31'b0, left_db}, 32'h0);
        end
        applyStimulus(LEFT, 1'b0);
        for (int k = 2; k <= 10; k++) begin
            applyStimulus(LEFT, 1'b0);
            checkOutput("heldLeftDb", {31'b0, left_db}, (k >= 7) ? 32'h1 : 32'h0);
        end
        idle(10);

        // Simultaneous right, up and parry presses.
        applyStimulus(RIGHT | UP | PARRY, 1'b0);
        for (int k = 2; k <= 10; k++) begin
            applyStimulus(RIGHT | UP | PARRY, 1'b0);
            checkOutput("simulDb", {26'b0, obsVec[5:0]}, (k >= 7) ? 32'h26 : 32'h0);
            checkOutput("simulParryPulse", {31'b0, parry_pulse}, (k == 7) ? 32'h1 : 32'h0);
        end
        idle(10);

        // Reset in the middle of a down press discards the partial count.
        for (int k = 0; k < 3; k++) applyStimulus(DOWN, 1'b0);
        applyStimulus(DOWN, 1'b1);
        applyStimulus(DOWN, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            applyStimulus(DOWN, 1'b0);
            checkOutput("midResetDownDb", {31'b0, down_db}, (k >= 7) ? 32'h1 : 32'h0);
        end
        idle(10);

        // Three separate parry presses give exactly three strobes.
        pulseCount = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 8; k++) begin
                applyStimulus(PARRY, 1'b0);
                if (parry_pulse) pulseCount++;
            end
            for (int k = 0; k < 8; k++) begin
                applyStimulus('0, 1'b0);
                if (parry_pulse) pulseCount++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus('0, 1'b0);
            if (parry_pulse) pulseCount++;
        end
        checkOutput("parryPulseCount", pulseCount, 32'd3);

        // Random independent bouncing on every button, with rare resets.
        rnd = '0;
        for (int ch = 0; ch < 6; ch++) holdLeft[ch] = $urandom_range(1, 9);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int ch = 0; ch < 6; ch++) begin
                if (holdLeft[ch] == 0) begin
                    rnd[ch] = ~rnd[ch];
                    holdLeft[ch] = $urandom_range(1, 9);
                end else begin
                    holdLeft[ch] = holdLeft[ch] - 1;
                end
            end
            applyStimulus(rnd, ($urandom_range(0, 99) == 0));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
